// File: rtl/mci_pkg.sv
// Shared MCI definitions used by the watchdog bank.
package mci_pkg;

    localparam int MCI_WDT_TIMEOUT_PERIOD_W = 64;
    localparam int MCI_WDT_NUM_TIMERS_DEF   = 2;

    typedef enum logic {
        WDT_INDEPENDENT = 1'b0,
        WDT_CASCADE     = 1'b1
    } mci_wdt_mode_e;

endpackage

// File: rtl/mci_wdt_stage.sv
// One watchdog stage: a wrapping timeout counter plus its sticky irq and expired flags.
module mci_wdt_stage
    import mci_pkg::*;
#(
    parameter int TIMEOUT_W = MCI_WDT_TIMEOUT_PERIOD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 active,
    input  logic                 restart,
    input  logic                 irq_clr,
    input  logic [TIMEOUT_W-1:0] period,
    output logic [TIMEOUT_W-1:0] count,
    output logic                 irq,
    output logic                 expired,
    output logic                 expire
);

    logic [TIMEOUT_W-1:0] count_q, count_d;
    logic                 irq_q, irq_d;
    logic                 exp_q, exp_d;
    logic                 hit;

    assign hit    = active & (count_q == period - TIMEOUT_W'(1));
    // Restart outranks a same-cycle expiry, so no irq is raised then.
    assign expire = hit & ~restart;

    always_comb begin
        count_d = count_q;
        exp_d   = exp_q;
        irq_d   = irq_q;
        if (restart) begin
            count_d = '0;
            exp_d   = 1'b0;
        end else if (hit) begin
            count_d = '0;
            exp_d   = 1'b1;
        end else if (active) begin
            count_d = count_q + TIMEOUT_W'(1);
        end
        if (expire)       irq_d = 1'b1;
        else if (irq_clr) irq_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            irq_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            irq_q   <= irq_d;
            exp_q   <= exp_d;
        end
    end

    assign count   = count_q;
    assign irq     = irq_q;
    assign expired = exp_q;

endmodule

// File: rtl/mci_wdt_gen2.sv
// Parametrised watchdog bank: independent timers or a cascaded chain ending in fatal.
module mci_wdt_gen2
    import mci_pkg::*;
#(
    parameter int NUM_TIMERS = MCI_WDT_NUM_TIMERS_DEF,
    parameter int TIMEOUT_W  = MCI_WDT_TIMEOUT_PERIOD_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mode,
    input  logic                            pause,
    input  logic [NUM_TIMERS-1:0]           en,
    input  logic [NUM_TIMERS*TIMEOUT_W-1:0] timeout_period,
    input  logic [NUM_TIMERS-1:0]           restart,
    input  logic [NUM_TIMERS-1:0]           irq_clr,
    output logic [NUM_TIMERS-1:0]           timeout_irq,
    output logic                            fatal,
    output logic [NUM_TIMERS*TIMEOUT_W-1:0] count
);

    logic                  mode_q, mode_d;
    logic                  fatal_q, fatal_d;
    logic                  mode_chg;
    logic                  cascade;
    logic [NUM_TIMERS-1:0] arm, active, restart_eff, expired, expire;
    logic                  unused_stage;

    assign mode_d   = mode;
    assign mode_chg = (mode != mode_q);
    assign cascade  = (mode_q == WDT_CASCADE);

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_stage
        logic [TIMEOUT_W-1:0] period;
        assign period = timeout_period[k*TIMEOUT_W +: TIMEOUT_W];

        if (k == 0) begin : g_head
            assign arm[k]         = 1'b1;
            assign restart_eff[k] = restart[k] | mode_chg;
        end else begin : g_tail
            // In a chain, restarting stage 0 disarms everything downstream.
            assign arm[k]         = ~cascade | expired[k-1];
            assign restart_eff[k] = restart[k] | mode_chg | (cascade & restart[0]);
        end

        assign active[k] = en[k] & ~pause & (period != '0) & arm[k];

        mci_wdt_stage #(
            .TIMEOUT_W (TIMEOUT_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .active  (active[k]),
            .restart (restart_eff[k]),
            .irq_clr (irq_clr[k]),
            .period  (period),
            .count   (count[k*TIMEOUT_W +: TIMEOUT_W]),
            .irq     (timeout_irq[k]),
            .expired (expired[k]),
            .expire  (expire[k])
        );
    end

    assign fatal_d = fatal_q | (cascade & expire[NUM_TIMERS-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= 1'b0;
            fatal_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            fatal_q <= fatal_d;
        end
    end

    assign fatal        = fatal_q;
    assign unused_stage = ^{expired[NUM_TIMERS-1], expire};

endmodule

// File: tb/tb_mci_wdt_gen2.sv
// Scoreboard bench for mci_wdt_gen2 with two 16-bit stages.
module tb_mci_wdt_gen2;

    localparam int N = 2;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst, mode, pause;
    logic [N-1:0]   en, restart, irq_clr;
    logic [N*W-1:0] timeout_period;
    logic [N-1:0]   timeout_irq;
    logic           fatal;
    logic [N*W-1:0] count;

    typedef struct {
        int          cyc;
        logic [34:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    mci_wdt_gen2 #(.NUM_TIMERS(N), .TIMEOUT_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .mode           (mode),
        .pause          (pause),
        .en             (en),
        .timeout_period (timeout_period),
        .restart        (restart),
        .irq_clr        (irq_clr),
        .timeout_irq    (timeout_irq),
        .fatal          (fatal),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] mk(input logic f, input logic [1:0] irq,
                                       input int c1, input int c0);
        return {f, irq, c1[15:0], c0[15:0]};
    endfunction

    function automatic logic [34:0] obs();
        return {fatal, timeout_irq, count[31:16], count[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic m);
        rst = 1'b1; mode = m; pause = 1'b0; en = '0; restart = '0; irq_clr = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; pause = 1'b0; en = 2'b11; restart = 2'b01; irq_clr = '0;
        timeout_period = {16'd1, 16'd1};
        sb.push_back('{1, mk(0, 2'b00, 0, 0)});
        for (int c = 0; c <= 1; c++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.v) begin
                    errors++;
                    $display("FAIL reset cyc=%0d got=%h exp=%h", c, obs(), e.v);
                end
            end
        end
    endtask

    task automatic test_independent();
        do_reset(1'b0);
        timeout_period = {16'd3, 16'd5};
        sb.push_back('{0, mk(0, 2'b00, 0, 0)});
        sb.push_back('{2, mk(0, 2'b00, 2, 2)});
        sb.push_back('{3, mk(0, 2'b10, 0, 3)});
        sb.push_back('{5, mk(0, 2'b11, 2, 0)});
        sb.push_back('{6, mk(0, 2'b11, 0, 1)});
        sb.push_back('{7, mk(0, 2'b01, 1, 2)});
        for (int c = 0; c <= 7; c++) begin
            en      = 2'b11;
            restart = (c == 0) ? 2'b11 : 2'b00;
            irq_clr = (c == 7) ? 2'b10 : 2'b00;
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.v) begin
                    errors++;
                    $display("FAIL independent cyc=%0d got=%h exp=%h", c, obs(), e.v);
                end
            end
        end
        irq_clr = '0;
    endtask

    task automatic test_cascade(input logic early_restart);
        do_reset(1'b1);
        timeout_period = {16'd6, 16'd4};
        if (!early_restart) begin
            sb.push_back('{0,  mk(0, 2'b00, 0, 0)});
            sb.push_back('{3,  mk(0, 2'b00, 0, 3)});
            sb.push_back('{4,  mk(0, 2'b01, 0, 0)});
            sb.push_back('{9,  mk(0, 2'b01, 5, 1)});
            sb.push_back('{10, mk(1, 2'b11, 0, 2)});
        end else begin
            sb.push_back('{6,  mk(0, 2'b01, 2, 2)});
            sb.push_back('{7,  mk(0, 2'b01, 0, 0)});
            sb.push_back('{10, mk(0, 2'b01, 0, 3)});
            sb.push_back('{11, mk(0, 2'b01, 0, 0)});
            sb.push_back('{12, mk(0, 2'b01, 1, 1)});
        end
        for (int c = 0; c <= 12; c++) begin
            en      = 2'b11;
            restart = (c == 0 || (early_restart && c == 7)) ? 2'b01 : 2'b00;
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.v) begin
                    errors++;
                    $display("FAIL cascade%0d cyc=%0d got=%h exp=%h", early_restart, c, obs(), e.v);
                end
            end
        end
        restart = '0;
    endtask

    task automatic test_pause();
        do_reset(1'b0);
        timeout_period = {16'd0, 16'd8};
        sb.push_back('{3,  mk(0, 2'b00, 0, 3)});
        sb.push_back('{6,  mk(0, 2'b00, 0, 3)});
        sb.push_back('{10, mk(0, 2'b00, 0, 7)});
        sb.push_back('{11, mk(0, 2'b01, 0, 0)});
        for (int c = 0; c <= 11; c++) begin
            en      = 2'b01;
            restart = (c == 0) ? 2'b01 : 2'b00;
            pause   = (c >= 4 && c <= 6);
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.v) begin
                    errors++;
                    $display("FAIL pause cyc=%0d got=%h exp=%h", c, obs(), e.v);
                end
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset(1'b0);
        timeout_period = {16'd0, 16'd4};
        sb.push_back('{3,  mk(0, 2'b00, 0, 3)});
        sb.push_back('{4,  mk(0, 2'b00, 0, 0)});
        sb.push_back('{7,  mk(0, 2'b00, 0, 3)});
        sb.push_back('{8,  mk(0, 2'b01, 0, 0)});
        sb.push_back('{9,  mk(0, 2'b01, 0, 1)});
        sb.push_back('{10, mk(0, 2'b01, 0, 0)});
        sb.push_back('{11, mk(0, 2'b01, 0, 0)});
        for (int c = 0; c <= 11; c++) begin
            en      = 2'b01;
            restart = (c == 0 || c == 4 || c == 10) ? 2'b01 : 2'b00;
            irq_clr = (c == 8) ? 2'b01 : 2'b00;
            pause   = (c >= 10);
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.v) begin
                    errors++;
                    $display("FAIL simultaneous cyc=%0d got=%h exp=%h", c, obs(), e.v);
                end
            end
        end
        pause = 1'b0; restart = '0; irq_clr = '0;
    endtask

    task automatic test_zero_period();
        do_reset(1'b1);
        timeout_period = {16'd3, 16'd0};
        for (int c = 0; c < 1000; c++) sb.push_back('{c, mk(0, 2'b00, 0, 0)});
        for (int c = 0; c < 1000; c++) begin
            en      = 2'b11;
            restart = (c == 0) ? 2'b01 : 2'b00;
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.v) begin
                    errors++;
                    $display("FAIL zero_period cyc=%0d got=%h exp=%h", c, obs(), e.v);
                end
            end
        end
    endtask

    task automatic test_mode_toggle();
        do_reset(1'b0);
        timeout_period = {16'd3, 16'd10};
        sb.push_back('{4,  mk(0, 2'b10, 1, 4)});
        sb.push_back('{5,  mk(0, 2'b10, 0, 0)});
        sb.push_back('{15, mk(0, 2'b11, 0, 0)});
        sb.push_back('{17, mk(0, 2'b11, 2, 2)});
        sb.push_back('{18, mk(1, 2'b11, 0, 3)});
        sb.push_back('{19, mk(0, 2'b00, 0, 0)});
        for (int c = 0; c <= 19; c++) begin
            en      = 2'b11;
            restart = (c == 0) ? 2'b11 : 2'b00;
            mode    = (c >= 5);
            rst     = (c == 19);
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.v) begin
                    errors++;
                    $display("FAIL mode_toggle cyc=%0d got=%h exp=%h", c, obs(), e.v);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_independent();
        test_cascade(1'b0);
        test_cascade(1'b1);
        test_pause();
        test_simultaneous();
        test_zero_period();
        test_mode_toggle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
